// File: rtl/weight_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the float16 weight RAM sequencer.
package weight_ctrl_pkg;
   localparam int DATA_WIDTH      = 16;
   localparam int KERNEL_SIZE_MAX = 5;
   localparam int SLICE_STRIDE    = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
   localparam int WEIGHT_RAM_MAX  = 27;
   localparam int WR_ADDR_WIDTH   = 5;
   localparam int RD_ADDR_WIDTH   = 10;
   localparam int SLICE_WIDTH     = SLICE_STRIDE * DATA_WIDTH;

   localparam logic [2:0]               KS_MAX_V     = 3'(KERNEL_SIZE_MAX);
   localparam logic [4:0]               SLICES_MAX_V = 5'(WEIGHT_RAM_MAX);
   localparam logic [RD_ADDR_WIDTH-1:0] STRIDE_V     = RD_ADDR_WIDTH'(SLICE_STRIDE);

   typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

   // Elements per slice for the legal kernel edges; a table avoids a multiplier.
   function automatic logic [4:0] ks_square(input logic [2:0] ks);
      case (ks)
         3'd1:    return 5'd1;
         3'd2:    return 5'd4;
         3'd3:    return 5'd9;
         3'd4:    return 5'd16;
         3'd5:    return 5'd25;
         default: return 5'd0;
      endcase
   endfunction
endpackage

// File: rtl/weight_addr_gen.sv
// Read-address sequencer: walks element, slice and pass counters and flags slice/pass ends.
module weight_addr_gen
   import weight_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               cfg_kernel_size,
   input  logic [4:0]               cfg_slice_num,
   input  logic [7:0]               cfg_repeat,
   output logic                     active,
   output logic [RD_ADDR_WIDTH-1:0] addr,
   output logic                     slice_last,
   output logic                     last
);
   logic [4:0]               kk_m1, slice_m1, elem, slice;
   logic [7:0]               rep, pass;
   logic [RD_ADDR_WIDTH-1:0] base;
   logic                     slice_end, pass_end;

   assign slice_end  = (elem == kk_m1);
   assign pass_end   = slice_end && (slice == slice_m1);
   assign slice_last = active && slice_end;
   assign last       = active && pass_end && (pass == rep);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         kk_m1    <= '0;
         slice_m1 <= '0;
         rep      <= '0;
         elem     <= '0;
         slice    <= '0;
         pass     <= '0;
         base     <= '0;
         addr     <= '0;
      end else if (start) begin
         active   <= 1'b1;
         kk_m1    <= ks_square(cfg_kernel_size) - 5'd1;
         slice_m1 <= cfg_slice_num - 5'd1;
         rep      <= cfg_repeat;
         elem     <= '0;
         slice    <= '0;
         pass     <= '0;
         base     <= '0;
         addr     <= '0;
      end else if (active) begin
         if (last) begin
            active <= 1'b0;
            elem   <= '0;
            slice  <= '0;
            pass   <= '0;
            base   <= '0;
            addr   <= '0;
         end else if (pass_end) begin
            // next pass starts on the following cycle with no gap
            elem  <= '0;
            slice <= '0;
            pass  <= pass + 8'd1;
            base  <= '0;
            addr  <= '0;
         end else if (slice_end) begin
            elem  <= '0;
            slice <= slice + 5'd1;
            base  <= base + STRIDE_V;
            addr  <= base + STRIDE_V;
         end else begin
            elem <= elem + 5'd1;
            addr <= addr + 10'd1;
         end
      end
   end
endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer: LOAD writes whole slices, READ streams used weights to the conv PE.
// Optional WEIGHT_CTRL_REPEAT_EN adds cfg_repeat for back-to-back repeated READ passes.
module weight_ram_ctrl
   import weight_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0]               cfg_kernel_size,
   input  logic [4:0]               cfg_slice_num,
`ifdef WEIGHT_CTRL_REPEAT_EN
   input  logic [7:0]               cfg_repeat,
`endif
   input  logic                     start_load,
   input  logic                     start_read,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [SLICE_WIDTH-1:0]   load_data,
   output logic                     ram_ena_wr,
   output logic [WR_ADDR_WIDTH-1:0] ram_addr_write,
   output logic [SLICE_WIDTH-1:0]   ram_din,
   output logic [RD_ADDR_WIDTH-1:0] ram_addr_read,
   input  logic [DATA_WIDTH-1:0]    ram_dout,
   output logic                     w_valid,
   output logic [DATA_WIDTH-1:0]    w_data,
   output logic                     w_slice_last,
   output logic                     w_last,
   output logic                     busy,
   output logic                     done
);
   state_t             state, state_n;
   logic               cfg_ok, start_rd, done_n;
   logic [4:0]         load_slice, load_m1;
   logic [7:0]         rep;
   logic               ag_active, ag_slice_last, ag_last;

`ifdef WEIGHT_CTRL_REPEAT_EN
   assign rep = cfg_repeat;
`else
   assign rep = 8'd0;
`endif

   assign cfg_ok = (cfg_kernel_size != 3'd0) && (cfg_kernel_size <= KS_MAX_V) &&
                   (cfg_slice_num != 5'd0) && (cfg_slice_num <= SLICES_MAX_V);

   assign load_ready     = (state == LOAD);
   assign ram_ena_wr     = load_ready & load_valid;
   assign ram_addr_write = load_slice;
   assign ram_din        = load_data;
   assign busy           = (state != IDLE);
   // the RAM output is already registered, so it lines up with the delayed flags
   assign w_data         = w_valid ? ram_dout : '0;

   always_comb begin
      state_n  = state;
      start_rd = 1'b0;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start_load && cfg_ok) begin
               state_n = LOAD;
            end else if (start_read && cfg_ok) begin
               state_n  = READ;
               start_rd = 1'b1;
            end
         end
         LOAD: begin
            if (ram_ena_wr && (load_slice == load_m1)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         READ:    if (ag_last) state_n = DRAIN;
         DRAIN: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         done         <= 1'b0;
         load_slice   <= '0;
         load_m1      <= '0;
         w_valid      <= 1'b0;
         w_slice_last <= 1'b0;
         w_last       <= 1'b0;
      end else begin
         state        <= state_n;
         done         <= done_n;
         w_valid      <= ag_active;
         w_slice_last <= ag_slice_last;
         w_last       <= ag_last;
         if (state == IDLE && start_load && cfg_ok) begin
            load_slice <= '0;
            load_m1    <= cfg_slice_num - 5'd1;
         end else if (ram_ena_wr) begin
            load_slice <= load_slice + 5'd1;
         end
      end
   end

   weight_addr_gen u_addr_gen (
      .clk             (clk),
      .rst             (rst),
      .start           (start_rd),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_slice_num   (cfg_slice_num),
      .cfg_repeat      (rep),
      .active          (ag_active),
      .addr            (ram_addr_read),
      .slice_last      (ag_slice_last),
      .last            (ag_last)
   );
endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Scoreboard bench for weight_ram_ctrl with a behavioural 1-cycle-read RAM and reference weight store.
`timescale 1ns/1ps
module tb_weight_ram_ctrl;
   import weight_ctrl_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [2:0]               cfg_kernel_size;
   logic [4:0]               cfg_slice_num;
`ifdef WEIGHT_CTRL_REPEAT_EN
   logic [7:0]               cfg_repeat;
`endif
   logic                     start_load, start_read, load_valid, load_ready;
   logic [SLICE_WIDTH-1:0]   load_data, ram_din;
   logic                     ram_ena_wr;
   logic [WR_ADDR_WIDTH-1:0] ram_addr_write;
   logic [RD_ADDR_WIDTH-1:0] ram_addr_read, prev_addr;
   logic [DATA_WIDTH-1:0]    ram_dout, w_data;
   logic                     w_valid, w_slice_last, w_last, busy, done;

   typedef struct {
      logic [15:0] data;
      logic        sl;
      logic        last;
      logic [9:0]  addr;
   } beat_t;
   typedef struct {
      logic [4:0]             addr;
      logic [SLICE_WIDTH-1:0] data;
   } wr_t;

   beat_t rq[$];
   wr_t   wq[$];
   beat_t bexp;
   wr_t   wexp;
   int    checks = 0, failures = 0, beats_seen = 0;

   logic [DATA_WIDTH-1:0] ref_mem [WEIGHT_RAM_MAX][SLICE_STRIDE];
   logic [DATA_WIDTH-1:0] ram [WEIGHT_RAM_MAX*SLICE_STRIDE];
   logic [15:0] fix0 [9] = '{16'h3c00, 16'h4000, 16'h0000, 16'h3c00, 16'h4000,
                             16'h3c00, 16'h4200, 16'h4000, 16'h3c00};

   weight_ram_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_slice_num   (cfg_slice_num),
`ifdef WEIGHT_CTRL_REPEAT_EN
      .cfg_repeat      (cfg_repeat),
`endif
      .start_load      (start_load),
      .start_read      (start_read),
      .load_valid      (load_valid),
      .load_ready      (load_ready),
      .load_data       (load_data),
      .ram_ena_wr      (ram_ena_wr),
      .ram_addr_write  (ram_addr_write),
      .ram_din         (ram_din),
      .ram_addr_read   (ram_addr_read),
      .ram_dout        (ram_dout),
      .w_valid         (w_valid),
      .w_data          (w_data),
      .w_slice_last    (w_slice_last),
      .w_last          (w_last),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural RAM: whole-slice write, registered single-word read
   always @(posedge clk) begin
      if (ram_ena_wr && int'(ram_addr_write) < WEIGHT_RAM_MAX)
         for (int e = 0; e < SLICE_STRIDE; e++)
            ram[int'(ram_addr_write)*SLICE_STRIDE + e] <= ram_din[e*DATA_WIDTH +: DATA_WIDTH];
      if (int'(ram_addr_read) < WEIGHT_RAM_MAX*SLICE_STRIDE) ram_dout <= ram[ram_addr_read];
      else ram_dout <= 16'hdead;
      prev_addr <= ram_addr_read;
   end

   // monitor: pops the scoreboards whenever the DUT writes or presents a weight beat
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_ena_wr) begin
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
               wexp = wq.pop_front();
               chk("wr_addr", 32'(ram_addr_write), 32'(wexp.addr));
               chk("wr_data", 32'(ram_din == wexp.data), 32'd1);
            end
         end
         if (w_valid) begin
            beats_seen++;
            if (rq.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
            else begin
               bexp = rq.pop_front();
               chk("w_data", 32'(w_data), 32'(bexp.data));
               chk("w_slice_last", 32'(w_slice_last), 32'(bexp.sl));
               chk("w_last", 32'(w_last), 32'(bexp.last));
               chk("rd_addr", 32'(prev_addr), 32'(bexp.addr));
            end
         end
      end
   end

   task automatic do_load(input int ks, input int n, input int mode, input bit fixed, input bit both);
      int acc = 0, cyc = 0, busy_bad = 0, wv_bad = 0;
      bit v;
      logic [SLICE_WIDTH-1:0] d;
      @(posedge clk); #1;
      cfg_kernel_size = 3'(ks); cfg_slice_num = 5'(n);
      start_load = 1'b1; start_read = both;
      @(posedge clk); #1;
      start_load = 1'b0;
      chk("load_entered", 32'(load_ready), 32'd1);
      while (acc < n && cyc < 40*n + 20) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = 1'($urandom % 2);
            default: v = (cyc % 4 == 0) || (cyc % 4 == 3);
         endcase
         for (int e = 0; e < SLICE_STRIDE; e++) d[e*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
         if (fixed && acc == 0)
            for (int e = 0; e < 9; e++) d[e*DATA_WIDTH +: DATA_WIDTH] = fix0[e];
         if (fixed && acc == 1) begin
            d[15:0]  = 16'h0000;
            d[31:16] = 16'h4200;
         end
         load_valid = v; load_data = d;
         if (!busy) busy_bad++;
         if (w_valid) wv_bad++;
         if (v && load_ready) begin
            wq.push_back('{addr: 5'(acc), data: d});
            for (int e = 0; e < SLICE_STRIDE; e++) ref_mem[acc][e] = d[e*DATA_WIDTH +: DATA_WIDTH];
            acc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      load_valid = 1'b0; start_read = 1'b0;
      chk("load_handshakes", 32'(acc), 32'(n));
      chk("load_busy_held", 32'(busy_bad), 32'd0);
      chk("load_no_read", 32'(wv_bad), 32'd0);
      chk("load_done", 32'(done), 32'd1);
      chk("load_idle", 32'(busy), 32'd0);
   endtask

   task automatic push_read(input int ks, input int n, input int rep);
      int kk = ks * ks;
      for (int p = 0; p <= rep; p++)
         for (int s = 0; s < n; s++)
            for (int e = 0; e < kk; e++)
               rq.push_back('{data: ref_mem[s][e], sl: (e == kk-1),
                              last: (p == rep && s == n-1 && e == kk-1),
                              addr: 10'(s*SLICE_STRIDE + e)});
   endtask

   task automatic issue_read(input int ks, input int n, input int rep);
      @(posedge clk); #1;
      cfg_kernel_size = 3'(ks); cfg_slice_num = 5'(n);
`ifdef WEIGHT_CTRL_REPEAT_EN
      cfg_repeat = 8'(rep);
`endif
      start_read = 1'b1;
      @(posedge clk); #1;
      start_read = 1'b0;
   endtask

   task automatic do_read(input int ks, input int n, input int rep);
      int N = n * ks * ks * (rep + 1);
      int vbad = 0, dbad = 0, bbad = 0;
      push_read(ks, n, rep);
      issue_read(ks, n, rep);
      for (int c = 1; c <= N + 2; c++) begin
         @(negedge clk);
         if (w_valid !== (c >= 2 && c <= N + 1)) vbad++;
         if (done !== (c == N + 2)) dbad++;
         if (busy !== (c <= N + 1)) bbad++;
      end
      #1;
      chk("read_valid_window", 32'(vbad), 32'd0);
      chk("read_done_timing", 32'(dbad), 32'd0);
      chk("read_busy", 32'(bbad), 32'd0);
      chk("read_beats_left", 32'(rq.size()), 32'd0);
   endtask

   task automatic try_bad(input int ks, input int n);
      @(posedge clk); #1;
      cfg_kernel_size = 3'(ks); cfg_slice_num = 5'(n);
      start_load = 1'b1; start_read = 1'b1;
      @(posedge clk); #1;
      start_load = 1'b0; start_read = 1'b0;
      chk("bad_start_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("bad_start_no_beat", 32'(w_valid), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tries;
      rst = 1'b1; start_load = 1'b0; start_read = 1'b0; load_valid = 1'b0;
      load_data = '0; cfg_kernel_size = 3'd0; cfg_slice_num = 5'd0;
`ifdef WEIGHT_CTRL_REPEAT_EN
      cfg_repeat = 8'd0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_w_valid", 32'(w_valid), 32'd0);
      chk("rst_flags", 32'({w_slice_last, w_last, load_ready, ram_ena_wr}), 32'd0);
      chk("rst_addrs", 32'({ram_addr_read, ram_addr_write}), 32'd0);
      chk("rst_w_data", 32'(w_data), 32'd0);
      rst = 1'b0;

      do_load(3, 2, 0, 1'b1, 1'b0);
      do_read(3, 2, 0);
      do_load(3, 2, 2, 1'b0, 1'b0);
      do_read(3, 2, 0);
      try_bad(0, 2);
      try_bad(3, 28);
      try_bad(6, 2);
      try_bad(3, 0);
      do_load(2, 3, 0, 1'b0, 1'b1);
      do_read(2, 3, 0);
      do_load(1, 1, 1, 1'b0, 1'b0);
      do_read(1, 1, 0);

      // abort a read on its 5th beat
      do_load(3, 2, 1, 1'b0, 1'b0);
      push_read(3, 2, 0);
      beats_seen = 0;
      issue_read(3, 2, 0);
      tries = 0;
      while (beats_seen < 5 && tries < 20) begin
         @(negedge clk); #1;
         tries++;
      end
      chk("abort_reached_beat5", 32'(beats_seen), 32'd5);
      rst = 1'b1;
      #1;
      chk("abort_w_valid", 32'(w_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rq.delete();
      @(negedge clk); #1;
      rst = 1'b0;
      tries = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || w_valid) tries++;
      end
      chk("abort_no_done", 32'(tries), 32'd0);
      do_read(3, 2, 0);

      do_load(5, 27, 1, 1'b0, 1'b0);
      do_read(5, 27, 0);
`ifdef WEIGHT_CTRL_REPEAT_EN
      do_read(5, 27, 1);
      do_read(2, 3, 2);
`endif
      for (int i = 0; i < 4; i++) begin
         int ks = $urandom_range(1, 5);
         int n  = $urandom_range(1, 6);
         do_load(ks, n, 1, 1'b0, 1'b0);
         do_read(ks, n, 0);
      end
      repeat (2) @(negedge clk);
      chk("writes_left", 32'(wq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
